// File: rtl/vending_pkg.sv
// Shared definitions for the vending front end: coin codes and debouncer states.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_QUAL_HI,
    DB_HELD,
    DB_QUAL_LO
  } db_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchroniser, then a debouncer that strobes coin_event
// exactly once per qualified high pulse.
module coin_debounce
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sense,
  output logic coin_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          event_q, event_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_IDLE;
      count_q <= '0;
      event_q <= 1'b0;
    end else begin
      sync1_q <= sense;
      sync2_q <= sync1_q;
      state_q <= state_d;
      count_q <= count_d;
      event_q <= event_d;
    end
  end

  // With a single-cycle qualification window the QUAL states are skipped entirely.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    event_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q) begin
          if (LAST == ONE) begin
            state_d = DB_HELD;
            count_d = '0;
            event_d = 1'b1;
          end else begin
            state_d = DB_QUAL_HI;
            count_d = ONE;
          end
        end
      end
      DB_QUAL_HI: begin
        if (!sync2_q) begin
          state_d = DB_IDLE;
          count_d = '0;
        end else if (count_q + ONE == LAST) begin
          state_d = DB_HELD;
          count_d = '0;
          event_d = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end
      DB_HELD: begin
        if (!sync2_q) begin
          if (LAST == ONE) begin
            state_d = DB_IDLE;
            count_d = '0;
          end else begin
            state_d = DB_QUAL_LO;
            count_d = ONE;
          end
        end
      end
      DB_QUAL_LO: begin
        if (sync2_q) begin
          state_d = DB_HELD;
          count_d = '0;
        end else if (count_q + ONE == LAST) begin
          state_d = DB_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: begin
        state_d = DB_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign coin_event = event_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces both sensors and holds one coin code under valid/ready.
// Define COIN_ACCEPTOR_STATS_EN to add saturating accepted/rejected counters.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sense_5,
  input  logic        sense_10,
  input  logic        accept_en,
  output logic [1:0]  coin,
  output logic        coin_valid,
  input  logic        coin_ready,
  output logic        reject
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [15:0] accepted_cnt,
  output logic [15:0] rejected_cnt
`endif
);

  logic       ev5, ev10, single_ev, drain;
  logic [1:0] ev_code;
  logic [1:0] coin_q, coin_d;
  logic       valid_q, valid_d;
  logic       reject_q, reject_d;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clk        (clk),
    .reset      (reset),
    .sense      (sense_5),
    .coin_event (ev5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clk        (clk),
    .reset      (reset),
    .sense      (sense_10),
    .coin_event (ev10)
  );

  assign single_ev = ev5 ^ ev10;
  assign ev_code   = ev5 ? COIN_5 : COIN_10;
  assign drain     = valid_q & coin_ready;

  // A handshake always retires the held coin; a new coin may refill the slot on the same edge.
  always_comb begin
    coin_d   = coin_q;
    valid_d  = valid_q;
    reject_d = 1'b0;
    if (drain) begin
      coin_d  = COIN_NONE;
      valid_d = 1'b0;
    end
    if (ev5 && ev10) begin
      reject_d = 1'b1;
    end else if (single_ev) begin
      if (!accept_en) begin
        reject_d = 1'b1;
      end else if (!valid_q || drain) begin
        coin_d  = ev_code;
        valid_d = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coin_q   <= COIN_NONE;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      coin_q   <= coin_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
    end
  end

  assign coin       = coin_q;
  assign coin_valid = valid_q;
  assign reject     = reject_q;

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] accepted_cnt_q, accepted_cnt_d;
  logic [15:0] rejected_cnt_q, rejected_cnt_d;

  always_comb begin
    accepted_cnt_d = accepted_cnt_q;
    rejected_cnt_d = rejected_cnt_q;
    if (drain && accepted_cnt_q != 16'hFFFF) accepted_cnt_d = accepted_cnt_q + 16'd1;
    if (reject_d && rejected_cnt_q != 16'hFFFF) rejected_cnt_d = rejected_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accepted_cnt_q <= '0;
      rejected_cnt_q <= '0;
    end else begin
      accepted_cnt_q <= accepted_cnt_d;
      rejected_cnt_q <= rejected_cnt_d;
    end
  end

  assign accepted_cnt = accepted_cnt_q;
  assign rejected_cnt = rejected_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor with DEBOUNCE_CYCLES = 4: table of pulse
// scenarios plus hand-written sequences for slot-full, back-to-back and reset cases.
module tb_coin_acceptor;

  logic        clk;
  logic        reset;
  logic        sense_5;
  logic        sense_10;
  logic        accept_en;
  logic        coin_ready;
  logic [1:0]  coin;
  logic        coin_valid;
  logic        reject;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] accepted_cnt;
  logic [15:0] rejected_cnt;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;
  int rej_seen     = 0;
  int rej_long     = 0;
  int idle_bad     = 0;
  logic rej_prev   = 1'b0;

  coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sense_5    (sense_5),
    .sense_10   (sense_10),
    .accept_en  (accept_en),
    .coin       (coin),
    .coin_valid (coin_valid),
    .coin_ready (coin_ready),
    .reject     (reject)
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    .accepted_cnt (accepted_cnt),
    .rejected_cnt (rejected_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe the strobe and idle-code rules on every falling edge.
  always @(negedge clk) begin
    if (reject) rej_seen++;
    if (reject && rej_prev) rej_long++;
    rej_prev = reject;
    if (!coin_valid && coin !== 2'b00) idle_bad++;
  end

  typedef struct {
    string      name;
    int         len5;
    int         len10;
    logic       acc;
    logic [1:0] exp_code;
    int         exp_valid;
    int         exp_rej;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives the sensors high for len5/len10 edges from the next edge, watching the slot.
  task automatic apply_stimulus(input int len5, input int len10, input int window,
                                output int valid_cycles, output logic [1:0] last_code);
    valid_cycles = 0;
    last_code    = 2'b00;
    sense_5  = (len5 > 0);
    sense_10 = (len10 > 0);
    for (int t = 0; t < window; t++) begin
      tick();
      if (coin_valid) begin
        valid_cycles++;
        last_code = coin;
      end
      sense_5  = (t + 1 < len5);
      sense_10 = (t + 1 < len10);
    end
  endtask

  initial begin
    int         vc;
    int         rej0;
    int         win;
    int         found;
    logic [1:0] code;
    logic       valid_at [10];
    logic [1:0] coin_at  [10];

    vecs[0] = '{"coin5_long",   10, 0,  1'b1, 2'b01, 1, 0};
    vecs[1] = '{"coin10_short", 0,  3,  1'b1, 2'b00, 0, 0};
    vecs[2] = '{"coin10_min",   0,  4,  1'b1, 2'b10, 1, 0};
    vecs[3] = '{"both_same",    6,  6,  1'b1, 2'b00, 0, 1};
    vecs[4] = '{"coin10_off",   0,  6,  1'b0, 2'b00, 0, 1};
    vecs[5] = '{"coin5_off",    4,  0,  1'b0, 2'b00, 0, 1};
    vecs[6] = '{"coin5_glitch", 2,  0,  1'b1, 2'b00, 0, 0};
    vecs[7] = '{"coin5_held",   20, 0,  1'b1, 2'b01, 1, 0};

    reset      = 1'b0;
    sense_5    = 1'b0;
    sense_10   = 1'b0;
    accept_en  = 1'b1;
    coin_ready = 1'b1;
    tick();
    tick();
    check_output("reset_coin",   int'(coin),       0);
    check_output("reset_valid",  int'(coin_valid), 0);
    check_output("reset_reject", int'(reject),     0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      accept_en  = vecs[i].acc;
      coin_ready = 1'b1;
      rej0 = rej_seen;
      win  = ((vecs[i].len5 > vecs[i].len10) ? vecs[i].len5 : vecs[i].len10) + 14;
      apply_stimulus(vecs[i].len5, vecs[i].len10, win, vc, code);
      check_output({vecs[i].name, "_valid_cycles"}, vc, vecs[i].exp_valid);
      check_output({vecs[i].name, "_code"}, int'(code), int'(vecs[i].exp_code));
      check_output({vecs[i].name, "_rejects"}, rej_seen - rej0, vecs[i].exp_rej);
    end
    accept_en = 1'b1;

    // Exact latency: valid for one cycle after edge 6 only.
    coin_ready = 1'b1;
    rej0 = rej_seen;
    sense_5 = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      valid_at[t] = coin_valid;
      coin_at[t]  = coin;
      sense_5 = (t + 1 < 10);
    end
    check_output("lat_valid_e5", int'(valid_at[5]), 0);
    check_output("lat_valid_e6", int'(valid_at[6]), 1);
    check_output("lat_coin_e6",  int'(coin_at[6]),  1);
    check_output("lat_valid_e7", int'(valid_at[7]), 0);
    apply_stimulus(0, 0, 12, vc, code);
    check_output("lat_rejects", rej_seen - rej0, 0);

    // Slot full: second coin is rejected, held code untouched, then drained.
    coin_ready = 1'b0;
    apply_stimulus(6, 0, 14, vc, code);
    check_output("full_first_code", int'(code), 1);
    rej0 = rej_seen;
    apply_stimulus(0, 6, 20, vc, code);
    check_output("full_valid_cycles", vc, 20);
    check_output("full_held_code", int'(code), 1);
    check_output("full_rejects", rej_seen - rej0, 1);
    coin_ready = 1'b1;
    tick();
    check_output("full_drain_valid", int'(coin_valid), 0);
    check_output("full_drain_coin",  int'(coin),       0);

    // Back-to-back: drain of 01 and load of 10 on the same edge.
    coin_ready = 1'b0;
    apply_stimulus(6, 0, 14, vc, code);
    rej0 = rej_seen;
    sense_10 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      sense_10 = (t + 1 < 6);
    end
    check_output("b2b_before_coin", int'(coin), 1);
    coin_ready = 1'b1;
    tick();
    check_output("b2b_load_valid", int'(coin_valid), 1);
    check_output("b2b_load_coin",  int'(coin),       2);
    tick();
    check_output("b2b_drain_valid", int'(coin_valid), 0);
    apply_stimulus(0, 0, 12, vc, code);
    check_output("b2b_rejects", rej_seen - rej0, 0);

    // Reset while holding a coin, sensor kept high across the reset.
    coin_ready = 1'b0;
    apply_stimulus(6, 0, 14, vc, code);
    rej0 = rej_seen;
    sense_5 = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_output("rst_async_valid", int'(coin_valid), 0);
    check_output("rst_async_coin",  int'(coin),       0);
    tick();
    tick();
    reset = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (coin_valid) found = i + 1;
    end
    check_output("rst_requal_latency", found, 7);
    check_output("rst_requal_coin", int'(coin), 1);
    check_output("rst_rejects", rej_seen - rej0, 0);
    sense_5 = 1'b0;
    coin_ready = 1'b1;
    apply_stimulus(0, 0, 14, vc, code);

`ifdef COIN_ACCEPTOR_STATS_EN
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_output("stats_reset_acc", int'(accepted_cnt), 0);
    check_output("stats_reset_rej", int'(rejected_cnt), 0);
    coin_ready = 1'b1;
    accept_en  = 1'b1;
    apply_stimulus(6, 0, 20, vc, code);
    apply_stimulus(0, 6, 20, vc, code);
    apply_stimulus(6, 0, 20, vc, code);
    accept_en = 1'b0;
    apply_stimulus(6, 0, 20, vc, code);
    accept_en = 1'b1;
    apply_stimulus(6, 6, 20, vc, code);
    check_output("stats_accepted", int'(accepted_cnt), 3);
    check_output("stats_rejected", int'(rejected_cnt), 2);
`endif

    check_output("reject_single_cycle", rej_long, 0);
    check_output("idle_coin_zero", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end block that turns the two raw coin-slot sensor lines into the 2-bit coin codes consumed by the vending state machine (00 = no coin, 01 = 5-dollar, 10 = 10-dollar). It synchronises and debounces each sensor, detects one coin per stable pulse, and holds the resulting code under a valid/ready handshake until the vending machine takes it. Coins that cannot be accepted raise a one-cycle `reject` strobe that drives the coin-return gate.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples needed to qualify a level change (legal range ≥ 1).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `sense_5`  in  1  raw 5-dollar sensor, asynchronous to `clk`, high while a coin passes.
- `sense_10`  in  1  raw 10-dollar sensor, asynchronous to `clk`.
- `accept_en`  in  1  1 = coins may be accepted; 0 = every detected coin is rejected.
- `coin`  out  2  coin code; 2'b00 whenever `coin_valid` = 0.
- `coin_valid`  out  1  `coin` holds an untaken coin.
- `coin_ready`  in  1  consumer takes `coin` on an edge where `coin_valid` & `coin_ready`.
- `reject`  out  1  one-cycle strobe: a detected coin was discarded and must be returned.

## Operation
- Per sensor: 2-flop synchroniser, then debouncer FSM with counter of width $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: synced = 1 → QUAL_HI, count = 1; else stay.
  - QUAL_HI: synced = 1 → count+1; when count reaches DEBOUNCE_CYCLES → HELD and registered `event` strobe for one cycle. synced = 0 → IDLE, count = 0, no event.
  - HELD: synced = 0 → QUAL_LO, count = 1.
  - QUAL_LO: synced = 0 → count+1; at DEBOUNCE_CYCLES → IDLE. synced = 1 → HELD, count = 0.
  - Exactly one event per qualified high pulse, however long it is held.
- Holding slot (one entry), evaluated per edge in this priority order:
  - `event5` and `event10` in the same cycle → `reject`, slot unchanged.
  - single event with `accept_en` = 0 → `reject`.
  - single event, slot empty, or slot being drained this edge (`coin_valid` & `coin_ready`) → load code, `coin_valid` = 1.
  - single event, slot full and not draining → `reject`, held code unchanged.
  - no event, drain → `coin_valid` = 0, `coin` = 2'b00.
- `coin_ready` is ignored while `coin_valid` = 0. `coin` is stable while `coin_valid` = 1 and `coin_ready` = 0.
- Reset values: `coin` = 2'b00, `coin_valid` = 0, `reject` = 0, synchronisers 0, FSMs IDLE, counters 0.
- Reset asserted mid-operation discards any held coin without asserting `reject`. After release, a sensor that is still high must qualify again from IDLE.

## Timing
- Sensor first sampled high at edge 0 → event strobe after edge 1+DEBOUNCE_CYCLES → `coin_valid` high after edge 2+DEBOUNCE_CYCLES.
- `reject` is high in the cycle after the qualifying event edge, for exactly one cycle.
- Load and drain on the same edge are a legal back-to-back transfer with no bubble.
- No combinational path from `coin_ready` to any output.

## Configuration
- `COIN_ACCEPTOR_STATS_EN` defined: adds outputs `accepted_cnt[15:0]` (increments on each handshake) and `rejected_cnt[15:0]` (increments on each `reject`). Both saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `vending_pkg`: coin code constants `COIN_NONE` = 2'b00, `COIN_5` = 2'b01, `COIN_10` = 2'b10, and the debouncer state enum.
- Sub-module `coin_debounce`: synchroniser, FSM and counter, parameterised by DEBOUNCE_CYCLES, instantiated once per sensor.

## Test plan
- DEBOUNCE_CYCLES = 4, `sense_5` high for 10 cycles, `coin_ready` = 1 → one `coin` = 01 with `coin_valid` for one cycle, rising 6 cycles after the first sample, no `reject`.
- `sense_10` high for 3 cycles (less than 4) then low → no `coin_valid`, no `reject`. A later 4-cycle pulse → `coin` = 10.
- `coin_ready` held 0: 5-dollar coin, then 10-dollar coin → `coin` stays 01, `reject` pulses once. Then raise `coin_ready` → 01 taken, `coin` = 00.
- Both sensors pulse identically (same cycles) → single `reject`, `coin_valid` stays 0.
- `accept_en` = 0 with a 10-dollar coin → `reject`, no `coin_valid`. Reset asserted while a coin is held → `coin_valid` 0 immediately, no `reject`.
- With `COIN_ACCEPTOR_STATS_EN`: 3 accepted coins and 2 rejected coins → `accepted_cnt` = 3, `rejected_cnt` = 2.
